// File: rtl/ddr5_phy_crc_pkg.sv
// Shared types and helpers for the DDR5 PHY burst write-CRC generator.
// Holds burst geometry constants, the FSM state encoding and the per-nibble CRC-8 fold.
package ddr5_phy_crc_pkg;

  localparam int              CRC_W        = 8;
  localparam logic [CRC_W-1:0] DEFAULT_POLY = 8'h07;
  localparam logic [3:0]      BL16_LAST    = 4'd15;
  localparam logic [3:0]      BC8_LAST     = 4'd7;
  localparam int              CRC_BEATS    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_FILL,
    ST_CRC0,
    ST_CRC1
  } crc_state_e;

  // Four MSB-first shift steps, bit 0 of the nibble first.
  function automatic logic [CRC_W-1:0] crc_fold_nibble(input logic [CRC_W-1:0] crc,
                                                       input logic [3:0]       nib,
                                                       input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int k = 0; k < 4; k++) begin
      fb = c[CRC_W-1] ^ nib[k];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr5_phy_crc_lane.sv
// One CRC-8 accumulator for a single DQ nibble.
// init_i reseeds before folding so the first beat of a burst needs no extra cycle.
module ddr5_phy_crc_lane
  import ddr5_phy_crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] pCRC_POLY = DEFAULT_POLY,
  parameter logic [CRC_W-1:0] pCRC_INIT = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             fold_i,
  input  logic [3:0]       nib_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] base;

  assign base = init_i ? pCRC_INIT : crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= pCRC_INIT;
    end else if (fold_i) begin
      crc_q <= crc_fold_nibble(base, nib_i, pCRC_POLY);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ddr5_phy_crc_gen_burst.sv
// Burst-level write-CRC generator: forwards data beats, inserts BC8 fill,
// then appends two CRC beats per burst through a single output register.
module ddr5_phy_crc_gen_burst
  import ddr5_phy_crc_pkg::*;
#(
  parameter int               pDRAM_SIZE = 4,
  parameter logic [CRC_W-1:0] pCRC_POLY  = DEFAULT_POLY,
  parameter logic [CRC_W-1:0] pCRC_INIT  = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  crc_en_i,
  input  logic                  bc8_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [pDRAM_SIZE-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [pDRAM_SIZE-1:0] out_data_o,
  output logic                  out_crc_beat_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int NIBBLES = pDRAM_SIZE / 4;

  crc_state_e            state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  bc8_q, crc_en_q;
  logic                  adv, acc, last_data;
  logic                  lane_init, lane_fold;
  logic [pDRAM_SIZE-1:0] fold_data, crc_lo, crc_hi;
  logic                  ld, ld_crc_beat, ld_last;
  logic [pDRAM_SIZE-1:0] ld_data;
  logic                  vld_p1, crc_beat_p1, last_p1;
  logic [pDRAM_SIZE-1:0] data_p1;

  assign adv       = !vld_p1 | out_ready_i;
  assign acc       = in_valid_i & in_ready_o;
  assign last_data = (cnt == (bc8_q ? BC8_LAST : BL16_LAST));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bc8_q    <= 1'b0;
      crc_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE && acc) begin
        bc8_q    <= bc8_i;
        crc_en_q <= crc_en_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: if (acc) begin
        state_nxt = ST_DATA;
        cnt_nxt   = 4'd1;
      end
      ST_DATA: if (acc) begin
        cnt_nxt = cnt + 4'd1;
        if (last_data) begin
          if (bc8_q && crc_en_q) begin
            state_nxt = ST_FILL;
          end else if (crc_en_q) begin
            state_nxt = ST_CRC0;
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      ST_FILL: if (adv) begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == BL16_LAST) state_nxt = ST_CRC0;
      end
      ST_CRC0: if (adv) state_nxt = ST_CRC1;
      ST_CRC1: if (adv) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready_o  = adv & (state == ST_IDLE || state == ST_DATA);
    busy_o      = (state != ST_IDLE);
    lane_init   = (state == ST_IDLE) & in_valid_i & in_ready_o;
    lane_fold   = (in_valid_i & in_ready_o) | ((state == ST_FILL) & adv);
    fold_data   = (state == ST_FILL) ? '1 : in_data_i;
    ld          = 1'b0;
    ld_data     = in_data_i;
    ld_crc_beat = 1'b0;
    ld_last     = 1'b0;
    case (state)
      ST_IDLE: ld = in_valid_i & in_ready_o;
      ST_DATA: begin
        ld      = in_valid_i & in_ready_o;
        ld_last = last_data & !crc_en_q;
      end
      ST_FILL: begin
        ld      = adv;
        ld_data = '1;
      end
      ST_CRC0: begin
        ld          = adv;
        ld_data     = crc_lo;
        ld_crc_beat = 1'b1;
      end
      ST_CRC1: begin
        ld          = adv;
        ld_data     = crc_hi;
        ld_crc_beat = 1'b1;
        ld_last     = 1'b1;
      end
      default: ld = 1'b0;
    endcase
  end

  for (genvar n = 0; n < NIBBLES; n++) begin : g_lane
    logic [CRC_W-1:0] crc_n;
    ddr5_phy_crc_lane #(
      .pCRC_POLY(pCRC_POLY),
      .pCRC_INIT(pCRC_INIT)
    ) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .init_i(lane_init),
      .fold_i(lane_fold),
      .nib_i (fold_data[4*n +: 4]),
      .crc_o (crc_n)
    );
    assign crc_lo[4*n +: 4] = crc_n[3:0];
    assign crc_hi[4*n +: 4] = crc_n[7:4];
  end

  // p1: output register toward the serializer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      crc_beat_p1 <= 1'b0;
      last_p1     <= 1'b0;
    end else if (ld) begin
      vld_p1      <= 1'b1;
      data_p1     <= ld_data;
      crc_beat_p1 <= ld_crc_beat;
      last_p1     <= ld_last;
    end else if (out_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid_o    = vld_p1;
  assign out_data_o     = data_p1;
  assign out_crc_beat_o = crc_beat_p1;
  assign out_last_o     = last_p1;

endmodule

// File: tb/tb_ddr5_phy_crc_gen_burst.sv
// Scoreboard bench for ddr5_phy_crc_gen_burst at x16 (four independent nibble lanes).
// Directed bursts use hand-derived expectations; random bursts use a bit-serial reference model.
module tb_ddr5_phy_crc_gen_burst;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, crc_en, bc8, in_valid, in_ready;
  logic         out_valid, out_ready, out_crc_beat, out_last, busy;
  logic [W-1:0] in_data, out_data;

  always #5 clk = ~clk;

  ddr5_phy_crc_gen_burst #(
    .pDRAM_SIZE(W),
    .pCRC_POLY (8'h07),
    .pCRC_INIT (8'h00)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .crc_en_i      (crc_en),
    .bc8_i         (bc8),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_crc_beat_o(out_crc_beat),
    .out_last_o    (out_last),
    .busy_o        (busy)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         cb;
    logic         last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [W-1:0] d, input bit cb, input bit last);
    exp_t e;
    e.d    = d;
    e.cb   = cb;
    e.last = last;
    q.push_back(e);
  endtask

  // Reference CRC: one lane's bit stream, bit 0 of each nibble first, divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [W-1:0] s[$], input int lane);
    logic [7:0] c;
    logic       b;
    c = 8'h00;
    foreach (s[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = s[i][4*lane+k];
        if (c[7] ^ b) c = {c[6:0], 1'b0} ^ 8'h07;
        else          c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic push_model(input logic [W-1:0] data[16], input bit b8, input bit ce);
    logic [W-1:0] s[$];
    logic [W-1:0] lo, hi;
    logic [7:0]   c;
    int           n;
    n = b8 ? 8 : 16;
    for (int i = 0; i < n; i++) s.push_back(data[i]);
    if (b8 && ce) repeat (8) s.push_back('1);
    foreach (s[i]) push_exp(s[i], 1'b0, !ce && (i == int'(s.size()) - 1));
    if (ce) begin
      for (int l = 0; l < W/4; l++) begin
        c = ref_crc(s, l);
        lo[4*l +: 4] = c[3:0];
        hi[4*l +: 4] = c[7:4];
      end
      push_exp(lo, 1'b1, 1'b0);
      push_exp(hi, 1'b1, 1'b1);
    end
  endtask

  task automatic drive_beat(input logic [W-1:0] d);
    int t;
    bit got;
    t = 0;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!got && t < 500) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL accept_timeout: got no in_ready, expected accept within 500 cycles at %0t", $time);
    end
  endtask

  task automatic send_burst(input logic [W-1:0] data[16], input bit b8, input bit ce, input bit gaps);
    int n;
    n = b8 ? 8 : 16;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      if (i == 0) begin
        bc8    = b8;
        crc_en = ce;
      end
      drive_beat(data[i]);
      if (gaps) begin
        bc8    = 1'($urandom);
        crc_en = 1'($urandom);
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},    32'(out_valid),    32'd0);
    chk({tag, "_data"},     32'(out_data),     32'd0);
    chk({tag, "_crc_beat"}, 32'(out_crc_beat), 32'd0);
    chk({tag, "_last"},     32'(out_last),     32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 99) < 65) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on every transfer, plus stability under back-pressure.
  initial begin
    exp_t         e;
    logic         pv, pr, prst, pcb, pl;
    logic [W-1:0] pd;
    pv = 1'b0; pr = 1'b1; prst = 1'b1; pcb = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (pv && !pr && !prst) begin
        chk("hold_valid",    32'(out_valid),    32'd1);
        chk("hold_data",     32'(out_data),     32'(pd));
        chk("hold_crc_beat", 32'(out_crc_beat), 32'(pcb));
        chk("hold_last",     32'(out_last),     32'(pl));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %h, expected no beat at %0t", out_data, $time);
        end else begin
          e = q.pop_front();
          chk("beat_data",     32'(out_data),     32'(e.d));
          chk("beat_crc_flag", 32'(out_crc_beat), 32'(e.cb));
          chk("beat_last",     32'(out_last),     32'(e.last));
        end
      end
      pv = out_valid; pr = out_ready; prst = rst;
      pd = out_data; pcb = out_crc_beat; pl = out_last;
    end
  end

  initial begin
    logic [W-1:0] data[16];
    rst = 1'b1; crc_en = 1'b0; bc8 = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // BL16 all-zero with CRC
    for (int i = 0; i < 16; i++) begin data[i] = '0; push_exp('0, 1'b0, 1'b0); end
    push_exp(16'h0000, 1'b1, 1'b0);
    push_exp(16'h0000, 1'b1, 1'b1);
    send_burst(data, 1'b0, 1'b1, 1'b0);

    // BL16 all-ones: CRC 8'hD7 in every lane
    for (int i = 0; i < 16; i++) begin data[i] = '1; push_exp('1, 1'b0, 1'b0); end
    push_exp(16'h7777, 1'b1, 1'b0);
    push_exp(16'hDDDD, 1'b1, 1'b1);
    send_burst(data, 1'b0, 1'b1, 1'b0);

    // BC8 all-ones: fill makes it identical to the BL16 all-ones case
    for (int i = 0; i < 16; i++) push_exp('1, 1'b0, 1'b0);
    push_exp(16'h7777, 1'b1, 1'b0);
    push_exp(16'hDDDD, 1'b1, 1'b1);
    send_burst(data, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fill_crc_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("ready_after_crc1", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Only nibble 0 active: lane 0 gets 7/D, others stay 0
    for (int i = 0; i < 16; i++) begin data[i] = 16'h000F; push_exp(16'h000F, 1'b0, 1'b0); end
    push_exp(16'h0007, 1'b1, 1'b0);
    push_exp(16'h000D, 1'b1, 1'b1);
    send_burst(data, 1'b0, 1'b1, 1'b0);
    wait_drain();
    @(posedge clk);
    #1;

    // Reset after nine beats, then a clean all-zero burst must show no residue
    bc8 = 1'b0; crc_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data[i] = W'($urandom) | 16'h1;
      push_exp(data[i], 1'b0, 1'b0);
      drive_beat(data[i]);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("mid_rst");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_queue_empty", 32'(q.size()), 32'd0);
    for (int i = 0; i < 16; i++) begin data[i] = '0; push_exp('0, 1'b0, 1'b0); end
    push_exp(16'h0000, 1'b1, 1'b0);
    push_exp(16'h0000, 1'b1, 1'b1);
    send_burst(data, 1'b0, 1'b1, 1'b0);

    // Random bursts with stalls, gaps and mid-burst mode toggling
    rdy_rand = 1'b1;
    for (int b = 0; b < 50; b++) begin
      bit b8, ce;
      b8 = 1'($urandom);
      ce = 1'($urandom);
      for (int i = 0; i < 16; i++) data[i] = W'($urandom);
      push_model(data, b8, ce);
      send_burst(data, b8, ce, 1'b1);
    end
    wait_drain();
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_queue_empty", 32'(q.size()), 32'd0);
    chk("end_busy",        32'(busy),     32'd0);
    chk("end_valid",       32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
